// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared defaults and count/flag next-state helpers
// for the single-clock FIFO family.
package sync_fifo_pkg;

   localparam int unsigned DEF_DATA_W    = 16;
   localparam int unsigned DEF_ADDR_W    = 3;
   localparam int unsigned DEF_AFULL_TH  = 6;
   localparam int unsigned DEF_AEMPTY_TH = 2;

   typedef struct packed {
      logic full;
      logic empty;
      logic afull;
      logic aempty;
   } flags_t;

   function automatic int unsigned next_count(
      input int unsigned cnt,
      input logic        inc,
      input logic        dec
   );
      return cnt + 32'(inc) - 32'(dec);
   endfunction

   function automatic flags_t next_flags(
      input int unsigned cnt,
      input int unsigned depth,
      input int unsigned afull_th,
      input int unsigned aempty_th
   );
      flags_t f;
      f.full   = (cnt == depth);
      f.empty  = (cnt == 0);
      f.afull  = (cnt >= afull_th);
      f.aempty = (cnt <= aempty_th);
      return f;
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bundle of the FIFO.
// master = user of the FIFO, slave = the FIFO itself.
interface sync_fifo_param_if
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
) ();

   logic              flush;
   logic              wrt_en;
   logic [DATA_W-1:0] wrt_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              full;
   logic              empty;
   logic              almost_full;
   logic              almost_empty;
   logic [ADDR_W:0]   fill_count;
   logic              overflow;
   logic              underflow;

   modport master (
      output flush, wrt_en, wrt_data, rd_en,
      input  rd_data, rd_valid, full, empty,
      input  almost_full, almost_empty,
      input  fill_count, overflow, underflow
   );

   modport slave (
      input  flush, wrt_en, wrt_data, rd_en,
      output rd_data, rd_valid, full, empty,
      output almost_full, almost_empty,
      output fill_count, overflow, underflow
   );

endinterface

// File: rtl/sync_fifo_ram.sv
// sync_fifo_ram: DEPTH x DATA_W storage, synchronous write,
// asynchronous read so the top can register or prefetch the head.
module sync_fifo_ram #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with count, thresholds, sticky
// errors and flush. Define SYNC_FIFO_FWFT_EN for first-word fall-through.
module sync_fifo_param
   import sync_fifo_pkg::*;
#(
   parameter int unsigned DATA_W    = DEF_DATA_W,
   parameter int unsigned ADDR_W    = DEF_ADDR_W,
   parameter int unsigned AFULL_TH  = DEF_AFULL_TH,
   parameter int unsigned AEMPTY_TH = DEF_AEMPTY_TH
) (
   input logic              clk,
   input logic              rst_n,
   sync_fifo_param_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned PW    = ADDR_W + 1;

   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     cnt_q, cnt_d;
   logic              full_q, full_d;
   logic              empty_q, empty_d;
   logic              afull_q, afull_d;
   logic              aempty_q, aempty_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic [DATA_W-1:0] ram_rdata;
   logic              wr_acc;
   logic              pop;
   logic              load;
   flags_t            flg;

   sync_fifo_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (wr_acc),
      .waddr (wr_ptr_q[ADDR_W-1:0]),
      .wdata (bus.wrt_data),
      .raddr (rd_ptr_q[ADDR_W-1:0]),
      .rdata (ram_rdata)
   );

   always_comb begin
      wr_acc = bus.wrt_en && !full_q && !bus.flush;
      pop    = bus.rd_en && !empty_q && !bus.flush;
`ifdef SYNC_FIFO_FWFT_EN
      // refill the output register when it is free or being popped
      load = (wr_ptr_q != rd_ptr_q) && (empty_q || pop) && !bus.flush;
`else
      load = pop;
`endif

      wr_ptr_d = bus.flush ? '0 : wr_ptr_q + PW'(wr_acc);
      rd_ptr_d = bus.flush ? '0 : rd_ptr_q + PW'(load);
      cnt_d    = bus.flush ? '0
               : PW'(next_count(32'(cnt_q), wr_acc, pop));

      flg = next_flags(32'(cnt_d), DEPTH, AFULL_TH, AEMPTY_TH);

      full_d   = flg.full;
      afull_d  = flg.afull;
      aempty_d = flg.aempty;
`ifdef SYNC_FIFO_FWFT_EN
      empty_d    = !load && (empty_q || pop || bus.flush);
      rd_valid_d = !empty_d;
`else
      empty_d    = flg.empty;
      rd_valid_d = pop;
`endif

      ovf_d = !bus.flush && (ovf_q || (bus.wrt_en && full_q));
      unf_d = !bus.flush && (unf_q || (bus.rd_en && empty_q));

      rd_data_d = load ? ram_rdata : rd_data_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
         afull_q    <= 1'b0;
         aempty_q   <= 1'b1;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
         afull_q    <= afull_d;
         aempty_q   <= aempty_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = afull_q;
   assign bus.almost_empty = aempty_q;
   assign bus.fill_count   = cnt_q;
   assign bus.overflow     = ovf_q;
   assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: queue-model scoreboard bench for sync_fifo_param.
// Default build checks standard mode; SYNC_FIFO_FWFT_EN runs the FWFT set.
module tb_sync_fifo_param;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 3;
   localparam int DEPTH     = 8;
   localparam int AFULL_TH  = 6;
   localparam int AEMPTY_TH = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [DATA_W-1:0] model[$];
   logic [DATA_W-1:0] exp_q[$];
   logic              m_ovf = 1'b0;
   logic              m_unf = 1'b0;
   int                msz;

   sync_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   sync_fifo_param #(
      .DATA_W    (DATA_W),
      .ADDR_W    (ADDR_W),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   function automatic void model_clear();
      model.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endfunction

   // FIFO rules at queue level: flags are those seen before the edge
   function automatic void model_update(input logic f, input logic we,
                                        input logic [DATA_W-1:0] wd,
                                        input logic re);
      int  sz;
      bit  wok, rok;
      if (f) begin
         model.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
         return;
      end
      sz  = model.size();
      wok = we && (sz < DEPTH);
      rok = re && (sz > 0);
      if (rok) exp_q.push_back(model.pop_front());
      if (wok) model.push_back(wd);
      if (we && !wok) m_ovf = 1'b1;
      if (re && !rok) m_unf = 1'b1;
   endfunction

   task automatic step(input logic f, input logic we,
                       input logic [DATA_W-1:0] wd, input logic re);
      bus.flush    = f;
      bus.wrt_en   = we;
      bus.wrt_data = wd;
      bus.rd_en    = re;
      @(posedge clk);
      model_update(f, we, wd, re);
      #1;
   endtask

`ifndef SYNC_FIFO_FWFT_EN
   always @(negedge clk) begin
      msz = model.size();
      chk("status",
          {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
           bus.overflow, bus.underflow, bus.fill_count},
          {msz == DEPTH, msz == 0, msz >= AFULL_TH, msz <= AEMPTY_TH,
           m_ovf, m_unf, 4'(msz)});
      chk("rd_valid", bus.rd_valid, exp_q.size() != 0);
      if (bus.rd_valid && exp_q.size() != 0)
         chk("rd_data", bus.rd_data, exp_q.pop_front());
      exp_q.delete();
   end
`endif

   initial begin
      bus.flush    = 1'b0;
      bus.wrt_en   = 1'b0;
      bus.wrt_data = '0;
      bus.rd_en    = 1'b0;
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("reset_rd_data", bus.rd_data, 16'h0);
      chk("reset_rd_valid", bus.rd_valid, 1'b0);

`ifdef SYNC_FIFO_FWFT_EN
      step(0, 1, 16'hABCD, 0);
      @(negedge clk);
      chk("fwft_empty_e1", {bus.empty, bus.fill_count}, {1'b1, 4'd1});
      step(0, 1, 16'h1234, 0);
      @(negedge clk);
      chk("fwft_empty_e2", {bus.empty, bus.rd_valid}, 2'b01);
      chk("fwft_head", bus.rd_data, 16'hABCD);
      chk("fwft_cnt2", bus.fill_count, 4'd2);
      step(0, 0, 16'h0, 1);
      @(negedge clk);
      chk("fwft_head2", {bus.empty, bus.rd_data}, {1'b0, 16'h1234});
      step(0, 0, 16'h0, 1);
      @(negedge clk);
      chk("fwft_drain", {bus.empty, bus.rd_valid, bus.fill_count},
          {1'b1, 1'b0, 4'd0});
      step(0, 0, 16'h0, 1);
      @(negedge clk);
      chk("fwft_unf", bus.underflow, 1'b1);
      step(0, 0, 16'h0, 0);
`else
      // fill past full, then drain past empty
      for (int i = 1; i <= 9; i++) step(0, 1, 16'(i), 0);
      for (int i = 0; i < 9; i++) step(0, 0, 16'h0, 1);
      step(0, 0, 16'h0, 0);

      // steady state at count 4 across pointer wrap
      for (int i = 0; i < 4; i++) step(0, 1, 16'(16'h100 + i), 0);
      for (int i = 4; i < 24; i++) step(0, 1, 16'(16'h100 + i), 1);
      for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1);

      // flush wins over a same-cycle write and clears sticky errors
      for (int i = 0; i < 3; i++) step(0, 1, 16'(16'h200 + i), 0);
      step(1, 1, 16'hDEAD, 0);
      step(0, 0, 16'h0, 0);
      for (int i = 0; i < 2; i++) step(0, 1, 16'(16'h300 + i), 0);
      for (int i = 0; i < 3; i++) step(0, 0, 16'h0, 1);

      // random traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 31) == 0, 1'($urandom_range(0, 2) != 0),
              16'($urandom), 1'($urandom_range(0, 2) != 0));

      // asynchronous reset mid-burst
      step(1, 0, 16'h0, 0);
      for (int i = 0; i < 10; i++) step(0, 1, 16'(16'h400 + i), 0);
      step(0, 1, 16'h4FF, 1);
      #2 rst_n = 1'b0;
      model_clear();
      #1;
      chk("async_rst_flags",
          {bus.full, bus.empty, bus.almost_full, bus.almost_empty,
           bus.overflow, bus.underflow, bus.fill_count, bus.rd_valid},
          {1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0});
      chk("async_rst_data", bus.rd_data, 16'h0);
      bus.wrt_en = 1'b0;
      bus.rd_en  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step(0, 1, 16'(16'h500 + i), 0);
      for (int i = 0; i < 4; i++) step(0, 0, 16'h0, 1);
      step(0, 0, 16'h0, 0);
`endif

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO: the next generation of the team's FIFO blocks, generalised in data width and depth. Adds fill count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, synchronous flush and optional first-word fall-through. Used wherever producer and consumer share one clock: stream buffering between pipeline stages and in front of bus masters.

## Interface
- DATA_W, 16, word width in bits (>= 1)
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (ADDR_W >= 1)
- AFULL_TH, 6, almost_full asserts when fill_count >= AFULL_TH (1..DEPTH)
- AEMPTY_TH, 2, almost_empty asserts when fill_count <= AEMPTY_TH (0..DEPTH-1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous clear of contents and error flags
- wrt_en  in  1  write request
- wrt_data  in  DATA_W  write word
- rd_en  in  1  read request (pop)
- rd_data  out  DATA_W  read word
- rd_valid  out  1  rd_data holds a newly popped word (standard mode only)
- full  out  1  fill_count == DEPTH
- empty  out  1  no word available to read
- almost_full  out  1  threshold flag
- almost_empty  out  1  threshold flag
- fill_count  out  ADDR_W+1  words held
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Reset (rst_n low, asynchronous): pointers 0, rd_data 0, rd_valid 0, full 0, empty 1, almost_full 0, almost_empty 1, fill_count 0, overflow 0, underflow 0. Memory contents not reset.
- Write accepted iff wrt_en && !full; read accepted iff rd_en && !empty. Flags are sampled before the edge; a read does not free space for a same-cycle write.
- Rejected write: data dropped, overflow set. Rejected read: no pointer change, underflow set, rd_valid 0. Both sticky until flush or reset.
- fill_count: +1 on write only, -1 on read only, unchanged on both or neither. Pointers are ADDR_W+1 bits; the extra bit distinguishes full from empty at wrap-around (DEPTH-1 -> 0).
- All status outputs are registered and computed from the next-state count, so they are consistent with fill_count in every cycle.
- flush: highest priority over wrt_en/rd_en in the same cycle. Next edge: pointers 0, count 0, empty 1, full 0, errors 0, rd_valid 0; rd_data holds its value.
- Standard mode: an accepted read updates rd_data with the head word at the next edge and pulses rd_valid for one cycle.

## Timing
- Write at edge N: fill_count, empty, full and thresholds update at edge N.
- Standard mode read latency: 1 cycle (rd_en at edge N -> rd_data/rd_valid valid after edge N).
- Write into empty FIFO (standard): empty deasserts after the same edge; readable from the next cycle.
- Sustained simultaneous read+write: 1 word/cycle each, count constant, no bubbles.
- Reset deassertion: first write may occur at the first rising edge after rst_n goes high.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word fall-through. The head word is prefetched into an output register. rd_data shows the head whenever empty is 0, and rd_en acts as an acknowledge and pops. empty = output register not valid. A write into an empty FIFO deasserts empty after 2 edges. fill_count includes the prefetched word, and total capacity stays DEPTH. rd_valid is tied to !empty.
- Not defined: standard mode as above, 1-cycle read latency.

## Structure
- Package sync_fifo_pkg: default DATA_W/ADDR_W constants and the count/threshold next-state function, shared with future FIFO variants.
- One sub-module, sync_fifo_ram: DEPTH x DATA_W storage with synchronous write and one read port, instantiated once. Control, pointers, flags and the FWFT stage live in the top.

## Test plan
- Reset, then write 8 words 0x0001..0x0008 (defaults) -> full=1 after the 8th, almost_full from the 6th, fill_count=8. A 9th write sets overflow and data is unchanged.
- Read 8 words back -> 0x0001..0x0008 in order, 1-cycle latency (standard mode). The 9th rd_en sets underflow, and empty=1 with almost_empty=1 from count 2.
- Hold fill_count=4, drive wrt_en+rd_en for 20 cycles with incrementing data -> count stays 4, data stays in order across pointer wrap.
- Write 3 words, assert flush with wrt_en=1 -> count=0, empty=1, overflow/underflow cleared, write ignored.
- Assert rst_n low mid-burst, asynchronously between edges -> all outputs reach reset values immediately, and the FIFO is reusable after release.
- With SYNC_FIFO_FWFT_EN: one write 0xABCD into empty -> empty falls 2 edges later with rd_data=0xABCD before any rd_en, and rd_en then returns empty to 1.
